// File: rtl/alu_decode_stage_if.sv
// ============================================================================
// Module   : alu_decode_stage_if
// Brief    : Instruction-in / decoded-entry-out bus of the ALU decode stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_decode_stage_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic             ex_ready;
    logic             ex_valid;
    logic             add_en;
    logic             sub_en;
    logic             sll_en;
    logic             slt_en;
    logic             xor_en;
    logic             sra_en;
    logic             srl_en;
    logic             or_en;
    logic             and_en;
    logic             sign_valid;
    logic             imm_valid;
    logic [31:0]      imm;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [4:0]       rd_addr;
    logic             rd_we;
    logic             illegal_instr;
    logic [CNT_W-1:0] issue_cnt;

    // Decode-stage view.
    modport master (
        input  instr_valid, instr, ex_ready,
        output instr_ready, ex_valid,
               add_en, sub_en, sll_en, slt_en, xor_en, sra_en, srl_en, or_en, and_en,
               sign_valid, imm_valid, imm, rs1_addr, rs2_addr, rd_addr,
               rd_we, illegal_instr, issue_cnt
    );

    // Upstream-fetch / downstream-ALU view.
    modport slave (
        output instr_valid, instr, ex_ready,
        input  instr_ready, ex_valid,
               add_en, sub_en, sll_en, slt_en, xor_en, sra_en, srl_en, or_en, and_en,
               sign_valid, imm_valid, imm, rs1_addr, rs2_addr, rd_addr,
               rd_we, illegal_instr, issue_cnt
    );
endinterface

`default_nettype wire

// File: rtl/alu_decode_stage.sv
// ============================================================================
// Module   : alu_decode_stage
// Brief    : RV32I OP / OP-IMM decode into registered one-hot ALU controls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decode_stage #(
    parameter int CNT_W = 16
) (
    input  wire                       clk,
    input  wire                       rst_n,
    input  wire                       flush,
    alu_decode_stage_if.master        bus
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_F7_BASE    = 7'b0000000;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;

    localparam int c_EN_ADD = 8;
    localparam int c_EN_SUB = 7;
    localparam int c_EN_SLL = 6;
    localparam int c_EN_SLT = 5;
    localparam int c_EN_XOR = 4;
    localparam int c_EN_SRA = 3;
    localparam int c_EN_SRL = 2;
    localparam int c_EN_OR  = 1;
    localparam int c_EN_AND = 0;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_is_op;
    logic        w_is_opi;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_sh;

    logic [8:0]  w_en;
    logic        w_sign;
    logic        w_imm_valid;
    logic [31:0] w_imm;
    logic [4:0]  w_rs2;
    logic        w_legal;
    logic        w_rd_we;

    logic        w_accept;
    logic        w_consume;
    logic        w_ready;

    logic             r_ex_valid;
    logic [8:0]       r_en;
    logic             r_sign_valid;
    logic             r_imm_valid;
    logic [31:0]      r_imm;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic             r_rd_we;
    logic             r_illegal;
    logic [CNT_W-1:0] r_issue_cnt;

    assign w_opcode = bus.instr[6:0];
    assign w_f3     = bus.instr[14:12];
    assign w_f7     = bus.instr[31:25];
    assign w_is_op  = (w_opcode == c_OPC_OP);
    assign w_is_opi = (w_opcode == c_OPC_OP_IMM);
    assign w_imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign w_imm_sh = {27'b0, bus.instr[24:20]};

    // Enables, immediate and imm_valid stay zero unless the encoding is legal.
    always_comb begin
        w_en        = '0;
        w_sign      = 1'b0;
        w_imm_valid = 1'b0;
        w_imm       = '0;
        w_rs2       = '0;
        w_legal     = 1'b0;
        if (w_is_op) begin
            w_rs2 = bus.instr[24:20];
            case (w_f3)
                3'b000: begin
                    if (w_f7 == c_F7_BASE) begin
                        w_en[c_EN_ADD] = 1'b1;
                        w_legal        = 1'b1;
                    end else if (w_f7 == c_F7_ALT) begin
                        w_en[c_EN_SUB] = 1'b1;
                        w_legal        = 1'b1;
                    end
                end
                3'b101: begin
                    if (w_f7 == c_F7_BASE) begin
                        w_en[c_EN_SRL] = 1'b1;
                        w_legal        = 1'b1;
                    end else if (w_f7 == c_F7_ALT) begin
                        w_en[c_EN_SRA] = 1'b1;
                        w_legal        = 1'b1;
                    end
                end
                default: begin
                    if (w_f7 == c_F7_BASE) begin
                        w_legal = 1'b1;
                        case (w_f3)
                            3'b001:  w_en[c_EN_SLL] = 1'b1;
                            3'b010:  begin
                                w_en[c_EN_SLT] = 1'b1;
                                w_sign         = 1'b1;
                            end
                            3'b011:  w_en[c_EN_SLT] = 1'b1;
                            3'b100:  w_en[c_EN_XOR] = 1'b1;
                            3'b110:  w_en[c_EN_OR]  = 1'b1;
                            default: w_en[c_EN_AND] = 1'b1;
                        endcase
                    end
                end
            endcase
        end else if (w_is_opi) begin
            case (w_f3)
                3'b000: begin
                    w_en[c_EN_ADD] = 1'b1;
                    w_imm          = w_imm_i;
                    w_legal        = 1'b1;
                end
                3'b001: begin
                    if (w_f7 == c_F7_BASE) begin
                        w_en[c_EN_SLL] = 1'b1;
                        w_imm          = w_imm_sh;
                        w_legal        = 1'b1;
                    end
                end
                3'b010: begin
                    w_en[c_EN_SLT] = 1'b1;
                    w_sign         = 1'b1;
                    w_imm          = w_imm_i;
                    w_legal        = 1'b1;
                end
                // sltiu still sign-extends; the ALU compares the result unsigned.
                3'b011: begin
                    w_en[c_EN_SLT] = 1'b1;
                    w_imm          = w_imm_i;
                    w_legal        = 1'b1;
                end
                3'b100: begin
                    w_en[c_EN_XOR] = 1'b1;
                    w_imm          = w_imm_i;
                    w_legal        = 1'b1;
                end
                3'b101: begin
                    if (w_f7 == c_F7_BASE) begin
                        w_en[c_EN_SRL] = 1'b1;
                        w_imm          = w_imm_sh;
                        w_legal        = 1'b1;
                    end else if (w_f7 == c_F7_ALT) begin
                        w_en[c_EN_SRA] = 1'b1;
                        w_imm          = w_imm_sh;
                        w_legal        = 1'b1;
                    end
                end
                3'b110: begin
                    w_en[c_EN_OR] = 1'b1;
                    w_imm         = w_imm_i;
                    w_legal       = 1'b1;
                end
                default: begin
                    w_en[c_EN_AND] = 1'b1;
                    w_imm          = w_imm_i;
                    w_legal        = 1'b1;
                end
            endcase
            w_imm_valid = w_legal;
        end
    end

    assign w_rd_we   = w_legal && (bus.instr[11:7] != 5'd0);
    assign w_ready   = !flush && (!r_ex_valid || bus.ex_ready);
    assign w_accept  = bus.instr_valid && w_ready;
    assign w_consume = r_ex_valid && bus.ex_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_en         <= '0;
            r_sign_valid <= 1'b0;
            r_imm_valid  <= 1'b0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_rd_we      <= 1'b0;
            r_illegal    <= 1'b0;
            r_issue_cnt  <= '0;
        end else begin
            // A consumed legal entry counts even when a flush lands on the same edge.
            if (w_consume && !r_illegal) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if (flush) begin
                r_ex_valid <= 1'b0;
                r_en       <= '0;
                r_rd_we    <= 1'b0;
                r_illegal  <= 1'b0;
            end else if (w_accept) begin
                r_ex_valid   <= 1'b1;
                r_en         <= w_en;
                r_sign_valid <= w_sign;
                r_imm_valid  <= w_imm_valid;
                r_imm        <= w_imm;
                r_rs1        <= bus.instr[19:15];
                r_rs2        <= w_rs2;
                r_rd         <= bus.instr[11:7];
                r_rd_we      <= w_rd_we;
                r_illegal    <= !w_legal;
            end else if (w_consume) begin
                r_ex_valid <= 1'b0;
                r_en       <= '0;
                r_rd_we    <= 1'b0;
                r_illegal  <= 1'b0;
            end
        end
    end

    assign bus.instr_ready   = w_ready;
    assign bus.ex_valid      = r_ex_valid;
    assign bus.add_en        = r_en[c_EN_ADD];
    assign bus.sub_en        = r_en[c_EN_SUB];
    assign bus.sll_en        = r_en[c_EN_SLL];
    assign bus.slt_en        = r_en[c_EN_SLT];
    assign bus.xor_en        = r_en[c_EN_XOR];
    assign bus.sra_en        = r_en[c_EN_SRA];
    assign bus.srl_en        = r_en[c_EN_SRL];
    assign bus.or_en         = r_en[c_EN_OR];
    assign bus.and_en        = r_en[c_EN_AND];
    assign bus.sign_valid    = r_sign_valid;
    assign bus.imm_valid     = r_imm_valid;
    assign bus.imm           = r_imm;
    assign bus.rs1_addr      = r_rs1;
    assign bus.rs2_addr      = r_rs2;
    assign bus.rd_addr       = r_rd;
    assign bus.rd_we         = r_rd_we;
    assign bus.illegal_instr = r_illegal;
    assign bus.issue_cnt     = r_issue_cnt;

endmodule

`default_nettype wire

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
Decode/issue stage directly upstream of top_alu. It accepts one RV32I instruction through a valid/ready handshake and decodes OP (0110011) and OP-IMM (0010011) encodings. The decoded result is registered into one-hot ALU enables, sign_valid, imm_valid, imm and register-file addresses. The outputs drive top_alu's enable and immediate inputs and the register-file read and write addresses.

Parameters:
CNT_W, 16, width of the issued-instruction counter issue_cnt.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous pipeline flush
instr_valid  input  1  upstream instruction valid
instr  input  32  instruction word
instr_ready  output  1  stage can accept; combinational = !flush && (!ex_valid || ex_ready)
ex_ready  input  1  downstream (ALU/writeback) accepts current entry
ex_valid  output  1  registered entry valid
add_en, sub_en, sll_en, slt_en, xor_en, sra_en, srl_en, or_en, and_en  output  1 each  registered one-hot ALU enables
sign_valid  output  1  1 = signed compare (slt/slti); 0 otherwise
imm_valid  output  1  1 = OP-IMM (ALU uses imm instead of rd_data2)
imm  output  32  decoded immediate
rs1_addr, rs2_addr, rd_addr  output  5 each  register addresses
rd_we  output  1  writeback enable
illegal_instr  output  1  entry is not a supported ALU instruction
issue_cnt  output  CNT_W  count of legal entries consumed downstream

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output is 0, including ex_valid, enables, imm, addresses, rd_we, illegal_instr and issue_cnt. instr_ready therefore reads 1 while flush=0.
- Accept: on a clock edge with instr_valid && instr_ready, the decoded instr is loaded and ex_valid becomes 1 on the next cycle. Latency is 1 cycle.
- Hold: while ex_valid && !ex_ready, all outputs stay bit-stable and no new instruction is accepted.
- Drain: on ex_valid && ex_ready with no new accept, ex_valid goes to 0 and all enables, rd_we and illegal_instr go to 0. Back-to-back accept-while-draining is allowed, giving full throughput.
- flush: has priority. At the next edge ex_valid=0 and enables/rd_we/illegal_instr=0. No instruction is accepted in a flush cycle. issue_cnt is unaffected except that an entry consumed (ex_ready=1) in the same cycle as flush still counts.
- Enable invariant: at most one enable is high, and only when ex_valid=1 and illegal_instr=0.
- Address fields: rs1_addr=instr[19:15] and rd_addr=instr[11:7]. rs2_addr=instr[24:20] for OP and 0 for OP-IMM.
- Decode by funct3:
  - 000: OP with funct7=0000000 gives add_en; OP with 0100000 gives sub_en; OP-IMM gives add_en (addi).
  - 001: sll_en. OP needs funct7=0; OP-IMM needs imm[11:5]=0.
  - 010: slt_en, sign_valid=1.
  - 011: slt_en, sign_valid=0.
  - 100: xor_en.
  - 101: funct7/imm[11:5]=0000000 gives srl_en; 0100000 gives sra_en.
  - 110: or_en.
  - 111: and_en.
  - For OP, any funct7 other than the listed values is illegal.
- Immediates:
  - OP-IMM non-shift: imm = sign-extend(instr[31:20]). This includes sltiu: the sign-extended value is then compared unsigned.
  - OP-IMM shifts: imm = {27'b0, instr[24:20]}.
  - OP: imm=0, imm_valid=0.
- Illegal: any other opcode or bad funct7 still gives ex_valid=1 and illegal_instr=1, with all enables=0, rd_we=0 and imm=0.
- rd_we = legal && rd_addr != 0, so writes to x0 are suppressed but the entry still issues.
- issue_cnt: increments by 1 on each edge with ex_valid && ex_ready && !illegal_instr. It wraps modulo 2^CNT_W from all-ones to 0 with no saturation.
- Reset asserted mid-hold: outputs clear immediately and asynchronously; the held entry is lost.

Test Plan:
- Reset release, then instr=0xFFF08293 (addi x5,x1,-1) valid 1 cycle → next cycle: ex_valid=1, add_en=1, imm_valid=1, imm=0xFFFFFFFF, rs1=1, rs2=0, rd=5, rd_we=1, sign_valid=0.
- instr=0x402081B3 (sub x3,x1,x2) → sub_en=1, imm_valid=0, rs1=1, rs2=2, rd=3. Then 0x40325213 (srai x4,x4,3) → sra_en=1, imm=0x00000003, imm_valid=1.
- instr=0xFFF13093 (sltiu x1,x2,-1) → slt_en=1, sign_valid=0, imm=0xFFFFFFFF. Then slti with the same fields (0xFFF12093) → sign_valid=1.
- Backpressure: issue addi, hold ex_ready=0 for 3 cycles with a second instruction pending → outputs bit-stable, instr_ready=0, second instruction accepted only on the cycle ex_ready=1. issue_cnt increments exactly once per consumed entry.
- instr=0x00000073 (ecall) → ex_valid=1, illegal_instr=1, all enables=0, rd_we=0; after consumption issue_cnt is unchanged. addi x0,x0,0 (0x00000013) → add_en=1, rd_we=0, counted.
- Flush while an entry is held → next cycle ex_valid=0, enables=0, instr not accepted during flush. Force issue_cnt to 0xFFFF (CNT_W=16) and consume one legal entry → issue_cnt=0x0000. Assert rst_n=0 mid-hold → all outputs 0 without waiting for a clock edge.
